// File: rtl/mem_stage.sv
// Memory stage: latches EX results, issues one dcache request per load/store,
// aligns/extends load data and hands every instruction to writeback.
module mem_stage #(
    parameter int XLEN    = 64,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [4:0]         in_rd,
    input  logic               in_need_to_wb,
    input  logic               in_is_load,
    input  logic               in_is_store,
    input  logic               in_is_unsigned,
    input  logic [3:0]         in_ls_size,
    input  logic [XLEN-1:0]    in_ls_address,
    input  logic [XLEN-1:0]    in_store_data,
    input  logic [XLEN-1:0]    in_ex_result,
    output logic               dc_req_valid,
    input  logic               dc_req_ready,
    output logic [XLEN-1:0]    dc_req_addr,
    output logic               dc_req_we,
    output logic [XLEN-1:0]    dc_req_wdata,
    output logic [7:0]         dc_req_wmask,
    input  logic               dc_resp_valid,
    input  logic [XLEN-1:0]    dc_resp_rdata,
    output logic               wb_valid,
    output logic [PC_W-1:0]    wb_pc,
    output logic [INSTR_W-1:0] wb_instr,
    output logic [4:0]         wb_rd,
    output logic               wb_need_to_wb,
    output logic [XLEN-1:0]    wb_result,
    output logic               wb_misalign,
    output logic [4:0]         mem_byp_rd,
    output logic               mem_byp_need_to_wb,
    output logic [XLEN-1:0]    mem_byp_result
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [4:0]         r_rd;
    logic               r_need_to_wb;
    logic               r_is_load;
    logic               r_is_store;
    logic               r_is_unsigned;
    logic [3:0]         r_size;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_wdata;
    logic [7:0]         r_wmask;

    logic               w_accept;
    logic               w_is_mem;
    logic               w_misalign;
    logic [2:0]         w_off;
    logic [7:0]         w_wmask;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_shifted;
    logic [XLEN-1:0]    w_load_result;

    assign in_ready = (r_state == IDLE) & ~flush;
    assign w_accept = in_valid & in_ready;
    assign w_is_mem = in_is_load | in_is_store;
    assign w_off    = in_ls_address[2:0];

    assign w_misalign = (in_ls_size[1] & in_ls_address[0])
                      | (in_ls_size[2] & (|in_ls_address[1:0]))
                      | (in_ls_size[3] & (|in_ls_address[2:0]));

    always_comb begin
        w_wmask = 8'h00;
        case (in_ls_size)
            4'b0001: w_wmask = 8'h01 << w_off;
            4'b0010: w_wmask = 8'h03 << w_off;
            4'b0100: w_wmask = 8'h0F << w_off;
            4'b1000: w_wmask = 8'hFF;
            default: w_wmask = 8'h00;
        endcase
    end

    assign w_wdata   = in_store_data << {w_off, 3'b000};
    assign w_shifted = dc_resp_rdata >> {r_addr[2:0], 3'b000};

    always_comb begin
        w_load_result = w_shifted;
        case (r_size)
            4'b0001: w_load_result = {{(XLEN-8){~r_is_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            4'b0010: w_load_result = {{(XLEN-16){~r_is_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            4'b0100: w_load_result = {{(XLEN-32){~r_is_unsigned & w_shifted[31]}}, w_shifted[31:0]};
            default: w_load_result = w_shifted;
        endcase
    end

    assign dc_req_valid = (r_state == REQ);
    assign dc_req_addr  = {r_addr[XLEN-1:3], 3'b000};
    assign dc_req_we    = r_is_store;
    assign dc_req_wdata = r_wdata;
    assign dc_req_wmask = r_wmask;

    // A flush after the handshake must still swallow the response, hence DRAIN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_instr       <= '0;
            r_rd          <= '0;
            r_need_to_wb  <= 1'b0;
            r_is_load     <= 1'b0;
            r_is_store    <= 1'b0;
            r_is_unsigned <= 1'b0;
            r_size        <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wmask       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && w_is_mem && !w_misalign) begin
                        r_pc          <= in_pc;
                        r_instr       <= in_instr;
                        r_rd          <= in_rd;
                        r_need_to_wb  <= in_need_to_wb;
                        r_is_load     <= in_is_load;
                        r_is_store    <= in_is_store;
                        r_is_unsigned <= in_is_unsigned;
                        r_size        <= in_ls_size;
                        r_addr        <= in_ls_address;
                        r_wdata       <= w_wdata;
                        r_wmask       <= w_wmask;
                        r_state       <= REQ;
                    end
                end
                REQ: begin
                    if (flush)
                        r_state <= dc_req_ready ? DRAIN : IDLE;
                    else if (dc_req_ready)
                        r_state <= RESP;
                end
                RESP: begin
                    if (dc_resp_valid)
                        r_state <= IDLE;
                    else if (flush)
                        r_state <= DRAIN;
                end
                DRAIN: begin
                    if (dc_resp_valid)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_pc         <= '0;
            wb_instr      <= '0;
            wb_rd         <= '0;
            wb_need_to_wb <= 1'b0;
            wb_result     <= '0;
            wb_misalign   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (w_accept && (!w_is_mem || w_misalign)) begin
                wb_valid      <= 1'b1;
                wb_pc         <= in_pc;
                wb_instr      <= in_instr;
                wb_rd         <= in_rd;
                wb_need_to_wb <= ~w_is_mem & in_need_to_wb;
                wb_result     <= w_is_mem ? '0 : in_ex_result;
                wb_misalign   <= w_is_mem;
            end else if (r_state == RESP && dc_resp_valid && !flush) begin
                wb_valid      <= 1'b1;
                wb_pc         <= r_pc;
                wb_instr      <= r_instr;
                wb_rd         <= r_rd;
                wb_need_to_wb <= r_is_load & r_need_to_wb;
                wb_result     <= r_is_load ? w_load_result : '0;
                wb_misalign   <= 1'b0;
            end
        end
    end

    assign mem_byp_rd         = wb_rd;
    assign mem_byp_need_to_wb = wb_need_to_wb & wb_valid;
    assign mem_byp_result     = wb_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: passthrough, loads, stores,
// misalignment, flush and reset scenarios with hand-computed expectations.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic [4:0]  in_rd = '0;
    logic        in_need_to_wb = 1'b0;
    logic        in_is_load = 1'b0;
    logic        in_is_store = 1'b0;
    logic        in_is_unsigned = 1'b0;
    logic [3:0]  in_ls_size = '0;
    logic [63:0] in_ls_address = '0;
    logic [63:0] in_store_data = '0;
    logic [63:0] in_ex_result = '0;
    logic        dc_req_valid;
    logic        dc_req_ready = 1'b0;
    logic [63:0] dc_req_addr;
    logic        dc_req_we;
    logic [63:0] dc_req_wdata;
    logic [7:0]  dc_req_wmask;
    logic        dc_resp_valid = 1'b0;
    logic [63:0] dc_resp_rdata = '0;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [31:0] wb_instr;
    logic [4:0]  wb_rd;
    logic        wb_need_to_wb;
    logic [63:0] wb_result;
    logic        wb_misalign;
    logic [4:0]  mem_byp_rd;
    logic        mem_byp_need_to_wb;
    logic [63:0] mem_byp_result;

    int nChecks = 0;
    int nPass = 0;
    int nFail = 0;

    mem_stage dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_rd(in_rd),
        .in_need_to_wb(in_need_to_wb), .in_is_load(in_is_load),
        .in_is_store(in_is_store), .in_is_unsigned(in_is_unsigned),
        .in_ls_size(in_ls_size), .in_ls_address(in_ls_address),
        .in_store_data(in_store_data), .in_ex_result(in_ex_result),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_addr(dc_req_addr), .dc_req_we(dc_req_we),
        .dc_req_wdata(dc_req_wdata), .dc_req_wmask(dc_req_wmask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .wb_rd(wb_rd), .wb_need_to_wb(wb_need_to_wb),
        .wb_result(wb_result), .wb_misalign(wb_misalign),
        .mem_byp_rd(mem_byp_rd), .mem_byp_need_to_wb(mem_byp_need_to_wb),
        .mem_byp_result(mem_byp_result)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic uns,
                                 input logic [3:0] size, input logic [63:0] addr,
                                 input logic [63:0] sdata, input logic [63:0] exres,
                                 input logic [4:0] rd, input logic need);
        in_valid       = 1'b1;
        in_is_load     = ld;
        in_is_store    = st;
        in_is_unsigned = uns;
        in_ls_size     = size;
        in_ls_address  = addr;
        in_store_data  = sdata;
        in_ex_result   = exres;
        in_rd          = rd;
        in_need_to_wb  = need;
        in_pc          = in_pc + 64'd4;
    endtask

    task automatic runLoad(input string tag, input logic [63:0] addr, input logic [3:0] size,
                           input logic uns, input logic [63:0] rdata, input logic [63:0] exp);
        applyStimulus(1'b1, 1'b0, uns, size, addr, '0, '0, 5'd7, 1'b1);
        tick;
        in_valid = 1'b0;
        checkOutput({tag, "_req_valid"}, {63'd0, dc_req_valid}, 64'd1);
        checkOutput({tag, "_req_addr"}, dc_req_addr, {addr[63:3], 3'b000});
        dc_req_ready = 1'b1;
        tick;
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b1;
        dc_resp_rdata = rdata;
        tick;
        dc_resp_valid = 1'b0;
        checkOutput({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd1);
        checkOutput({tag, "_result"}, wb_result, exp);
        checkOutput({tag, "_byp_need"}, {63'd0, mem_byp_need_to_wb}, 64'd1);
    endtask

    initial begin
        tick;
        checkOutput("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        checkOutput("rst_req_valid", {63'd0, dc_req_valid}, 64'd0);
        checkOutput("rst_byp_need", {63'd0, mem_byp_need_to_wb}, 64'd0);
        checkOutput("rst_wb_result", wb_result, 64'd0);
        reset = 1'b0;
        tick;
        checkOutput("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // ALU passthrough, one-cycle wb pulse
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, '0, '0, 64'h1234, 5'd5, 1'b1);
        tick;
        in_valid = 1'b0;
        checkOutput("alu_wb_valid", {63'd0, wb_valid}, 64'd1);
        checkOutput("alu_result", wb_result, 64'h1234);
        checkOutput("alu_byp_rd", {59'd0, mem_byp_rd}, 64'd5);
        checkOutput("alu_byp_need", {63'd0, mem_byp_need_to_wb}, 64'd1);
        tick;
        checkOutput("alu_pulse_end", {63'd0, wb_valid}, 64'd0);
        checkOutput("alu_byp_gated", {63'd0, mem_byp_need_to_wb}, 64'd0);

        runLoad("lb_s", 64'h1003, 4'b0001, 1'b0, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80);
        runLoad("lb_u", 64'h1003, 4'b0001, 1'b1, 64'h00000000_80000000, 64'h00000000_00000080);
        runLoad("lh_s", 64'h1002, 4'b0010, 1'b0, 64'h00000000_ABCD0000, 64'hFFFFFFFF_FFFFABCD);
        runLoad("lw_s", 64'h1004, 4'b0100, 1'b0, 64'h76543210_00000000, 64'h00000000_76543210);
        runLoad("lwu",  64'h1004, 4'b0100, 1'b1, 64'hF6543210_00000000, 64'h00000000_F6543210);
        runLoad("ld",   64'h1008, 4'b1000, 1'b0, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D);

        // SH with dcache holding off ready for three cycles
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0010, 64'h1002, 64'hABCD, '0, 5'd9, 1'b1);
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("sh_req_valid", {63'd0, dc_req_valid}, 64'd1);
            checkOutput("sh_wmask", {56'd0, dc_req_wmask}, 64'h0C);
            checkOutput("sh_wdata", dc_req_wdata, 64'h00000000_ABCD0000);
            checkOutput("sh_we", {63'd0, dc_req_we}, 64'd1);
            checkOutput("sh_in_ready", {63'd0, in_ready}, 64'd0);
            tick;
        end
        dc_req_ready = 1'b1;
        tick;
        dc_req_ready = 1'b0;
        checkOutput("sh_req_dropped", {63'd0, dc_req_valid}, 64'd0);
        checkOutput("sh_resp_wait_ready", {63'd0, in_ready}, 64'd0);
        dc_resp_valid = 1'b1;
        tick;
        dc_resp_valid = 1'b0;
        checkOutput("sh_wb_valid", {63'd0, wb_valid}, 64'd1);
        checkOutput("sh_need", {63'd0, wb_need_to_wb}, 64'd0);
        checkOutput("sh_result", wb_result, 64'd0);

        // Misaligned LW: no dcache traffic
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0100, 64'h1006, '0, '0, 5'd3, 1'b1);
        tick;
        in_valid = 1'b0;
        checkOutput("mis_req_valid", {63'd0, dc_req_valid}, 64'd0);
        checkOutput("mis_wb_valid", {63'd0, wb_valid}, 64'd1);
        checkOutput("mis_flag", {63'd0, wb_misalign}, 64'd1);
        checkOutput("mis_need", {63'd0, wb_need_to_wb}, 64'd0);
        tick;

        // Flush in RESP, response arrives four cycles later
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1000, 64'h2000, '0, '0, 5'd4, 1'b1);
        tick;
        in_valid = 1'b0;
        dc_req_ready = 1'b1;
        tick;
        dc_req_ready = 1'b0;
        flush = 1'b1;
        #1;
        checkOutput("fl_resp_in_ready", {63'd0, in_ready}, 64'd0);
        tick;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("fl_drain_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("fl_drain_wb", {63'd0, wb_valid}, 64'd0);
            tick;
        end
        dc_resp_valid = 1'b1;
        dc_resp_rdata = 64'h1111;
        tick;
        dc_resp_valid = 1'b0;
        checkOutput("fl_drain_no_wb", {63'd0, wb_valid}, 64'd0);
        checkOutput("fl_drain_idle", {63'd0, in_ready}, 64'd1);

        // Flush in REQ before handshake drops the request
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001, 64'h3000, '0, '0, 5'd6, 1'b1);
        tick;
        in_valid = 1'b0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        #1;
        checkOutput("fl_req_dropped", {63'd0, dc_req_valid}, 64'd0);
        checkOutput("fl_req_idle", {63'd0, in_ready}, 64'd1);
        checkOutput("fl_req_no_wb", {63'd0, wb_valid}, 64'd0);

        // Flush and response in the same RESP cycle: straight back to IDLE
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1000, 64'h3008, '0, '0, 5'd6, 1'b1);
        tick;
        in_valid = 1'b0;
        dc_req_ready = 1'b1;
        tick;
        dc_req_ready = 1'b0;
        flush = 1'b1;
        dc_resp_valid = 1'b1;
        tick;
        flush = 1'b0;
        dc_resp_valid = 1'b0;
        #1;
        checkOutput("fl_same_no_wb", {63'd0, wb_valid}, 64'd0);
        checkOutput("fl_same_idle", {63'd0, in_ready}, 64'd1);

        // Flush in IDLE blocks accept but not an already-valid wb
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, '0, '0, 64'h55, 5'd8, 1'b1);
        tick;
        flush = 1'b1;
        in_ex_result = 64'h66;
        #1;
        checkOutput("fl_keeps_wb", {63'd0, wb_valid}, 64'd1);
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl_no_accept", {63'd0, wb_valid}, 64'd0);

        // Reset while in REQ and while wb_valid is high
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1000, 64'h4000, '0, '0, 5'd2, 1'b1);
        tick;
        in_valid = 1'b0;
        checkOutput("rr_req_valid", {63'd0, dc_req_valid}, 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("rr_req_drop", {63'd0, dc_req_valid}, 64'd0);
        reset = 1'b0;
        tick;
        checkOutput("rr_idle", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, '0, '0, 64'h77, 5'd1, 1'b1);
        tick;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("rr_wb_drop", {63'd0, wb_valid}, 64'd0);
        reset = 1'b0;
        tick;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
